// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP definitions.
//   tap_state_t    - IEEE 1149.1 TAP state encodings (4 bits, debug-visible)
//   op_bypass()    - BYPASS opcode (all ones) for a given IR width
//   OP_IDCODE      - IDCODE opcode value
//   OP_USER_BASE   - opcode of user data register 0; user k is OP_USER_BASE + k
//   IR_CAPTURE     - value loaded into the IR shift register in Capture-IR
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SHIFT_DR = 4'h2,
        EXIT1_DR = 4'h1,
        PAUSE_DR = 4'h3,
        EXIT2_DR = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SHIFT_IR = 4'hA,
        EXIT1_IR = 4'h9,
        PAUSE_IR = 4'hB,
        EXIT2_IR = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    localparam int OP_IDCODE    = 1;
    localparam int OP_USER_BASE = 2;
    localparam int IR_CAPTURE   = 1;   // {0...0, 2'b01}

    function automatic int op_bypass(input int ir_width);
        return (1 << ir_width) - 1;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller with state decodes.
//   tck, trst_n  - test clock, asynchronous active-low reset (to TLR)
//   tms          - test mode select, sampled on posedge tck
//   state        - current TAP state
//   capture_dr / shift_dr / update_dr, capture_ir / shift_ir / update_ir,
//   tlr          - one-hot style decodes of the current state
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tlr
);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:      state <= tms ? TLR      : RTI;
                RTI:      state <= tms ? SEL_DR   : RTI;
                SEL_DR:   state <= tms ? SEL_IR   : CAP_DR;
                CAP_DR:   state <= tms ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: state <= tms ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: state <= tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state <= tms ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state <= tms ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state <= tms ? SEL_DR   : RTI;
                SEL_IR:   state <= tms ? TLR      : CAP_IR;
                CAP_IR:   state <= tms ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: state <= tms ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: state <= tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state <= tms ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state <= tms ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state <= tms ? SEL_DR   : RTI;
                default:  state <= TLR;
            endcase
        end
    end

    assign capture_dr = (state == CAP_DR);
    assign shift_dr   = (state == SHIFT_DR);
    assign update_dr  = (state == UPD_DR);
    assign capture_ir = (state == CAP_IR);
    assign shift_ir   = (state == SHIFT_IR);
    assign update_ir  = (state == UPD_IR);
    assign tlr        = (state == TLR);

endmodule

// File: rtl/jtag_tap_core.sv
// jtag_tap_core: IEEE 1149.1 TAP with IR, BYPASS, IDCODE and user DRs.
//   tck, trst_n, tms, tdi - JTAG pins (trst_n asynchronous, active-low)
//   tdo, tdo_en           - serial output and its enable, both on negedge tck
//   tap_state             - current TAP state encoding (debug)
//   ir_q                  - active instruction
//   user_capture          - parallel capture data, slice k for user DR k
//   user_update           - parallel update registers, slice k for user DR k
//   user_update_stb       - one-tck-period strobe per user DR on update
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = 32'h4BA0_0477,
    parameter int          NUM_USER_DR   = 2,
    parameter int          USER_DR_WIDTH = 8
) (
    input  logic                                 tck,
    input  logic                                 trst_n,
    input  logic                                 tms,
    input  logic                                 tdi,
    output logic                                 tdo,
    output logic                                 tdo_en,
    output logic [3:0]                           tap_state,
    output logic [IR_WIDTH-1:0]                  ir_q,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0] user_capture,
    output logic [NUM_USER_DR*USER_DR_WIDTH-1:0] user_update,
    output logic [NUM_USER_DR-1:0]               user_update_stb
);

    localparam logic [IR_WIDTH-1:0] OP_BYP = IR_WIDTH'(op_bypass(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] OP_ID  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(IR_CAPTURE);

    tap_state_t state;
    logic capture_dr, shift_dr, update_dr;
    logic capture_ir, shift_ir, update_ir, tlr;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trst_n     (trst_n),
        .tms        (tms),
        .state      (state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tlr        (tlr)
    );

    assign tap_state = state;

    logic [IR_WIDTH-1:0]      ir_sr;
    logic                     bypass_sr;
    logic [31:0]              idcode_sr;
    logic [USER_DR_WIDTH-1:0] user_sr [NUM_USER_DR];

    // Instruction decode; any opcode not IDCODE or a user DR falls to BYPASS.
    logic                   sel_idcode;
    logic [NUM_USER_DR-1:0] sel_user;

    always_comb begin
        sel_idcode = (ir_q == OP_ID);
        for (int k = 0; k < NUM_USER_DR; k++) begin
            sel_user[k] = (ir_q == IR_WIDTH'(OP_USER_BASE + k));
        end
    end

    // IR shift register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sr <= '0;
        end else if (capture_ir) begin
            ir_sr <= IR_CAP;
        end else if (shift_ir) begin
            ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // DR shift registers: only the selected one captures or shifts.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            bypass_sr <= 1'b0;
            idcode_sr <= '0;
            for (int k = 0; k < NUM_USER_DR; k++) begin
                user_sr[k] <= '0;
            end
        end else if (capture_dr) begin
            if (sel_idcode) begin
                idcode_sr <= IDCODE_VALUE;
            end else if (sel_user == '0) begin
                bypass_sr <= 1'b0;
            end
            for (int k = 0; k < NUM_USER_DR; k++) begin
                if (sel_user[k]) begin
                    user_sr[k] <= user_capture[k*USER_DR_WIDTH +: USER_DR_WIDTH];
                end
            end
        end else if (shift_dr) begin
            if (sel_idcode) begin
                idcode_sr <= {tdi, idcode_sr[31:1]};
            end else if (sel_user == '0) begin
                bypass_sr <= tdi;
            end
            for (int k = 0; k < NUM_USER_DR; k++) begin
                if (sel_user[k]) begin
                    if (USER_DR_WIDTH > 1) begin
                        user_sr[k] <= {tdi, user_sr[k][USER_DR_WIDTH-1:1]};
                    end else begin
                        user_sr[k] <= USER_DR_WIDTH'(tdi);
                    end
                end
            end
        end
    end

    // TDO mux: LSB of the selected DR.
    logic dr_lsb;

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode) begin
            dr_lsb = idcode_sr[0];
        end
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (sel_user[k]) begin
                dr_lsb = user_sr[k][0];
            end
        end
    end

    // Negedge side: retimed TDO, instruction update, user updates and strobes.
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo             <= 1'b0;
            tdo_en          <= 1'b0;
            ir_q            <= OP_ID;
            user_update     <= '0;
            user_update_stb <= '0;
        end else begin
            tdo_en          <= shift_dr | shift_ir;
            user_update_stb <= '0;
            if (shift_ir) begin
                tdo <= ir_sr[0];
            end else if (shift_dr) begin
                tdo <= dr_lsb;
            end
            if (tlr) begin
                ir_q <= OP_ID;
            end else if (update_ir) begin
                ir_q <= ir_sr;
            end
            if (update_dr) begin
                for (int k = 0; k < NUM_USER_DR; k++) begin
                    if (sel_user[k]) begin
                        user_update[k*USER_DR_WIDTH +: USER_DR_WIDTH] <= user_sr[k];
                        user_update_stb[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // The BYPASS opcode is the decode fallthrough; kept for readability.
    logic unused_ok;
    assign unused_ok = ^OP_BYP;

endmodule

// File: tb/tb_jtag_tap_core.sv
module tb_jtag_tap_core;

    logic        tck;
    logic        trst_n;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  tap_state;
    logic [3:0]  ir_q;
    logic [15:0] user_capture;
    logic [15:0] user_update;
    logic [1:0]  user_update_stb;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    jtag_tap_core dut (
        .tck             (tck),
        .trst_n          (trst_n),
        .tms             (tms),
        .tdi             (tdi),
        .tdo             (tdo),
        .tdo_en          (tdo_en),
        .tap_state       (tap_state),
        .ir_q            (ir_q),
        .user_capture    (user_capture),
        .user_update     (user_update),
        .user_update_stb (user_update_stb)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // One tck cycle: drive inputs, let posedge and negedge pass, sample 1ns
    // after the negedge. Any enabled tdo bit is scored against the queue.
    task automatic tick(input logic tms_v, input logic tdi_v);
        tms = tms_v;
        tdi = tdi_v;
        @(posedge tck);
        @(negedge tck);
        #1;
        if (tdo_en === 1'b1) begin
            if (exp_q.size() == 0) chk("tdo_unexpected", 32'(tdo_en), 32'd0);
            else                   chk("tdo", 32'(tdo), 32'(exp_q.pop_front()));
        end
    endtask

    // From RTI, scan n DR bits; returns in Update-DR.
    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] want);
        for (int i = 0; i < n; i++) exp_q.push_back(want[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick(i == n - 1, din[i]);
        tick(1'b1, 1'b0);
        chk("dr_state_upd", 32'(tap_state), 32'h5);
        chk("dr_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // From RTI, scan the IR (capture value 4'b0001 comes out); returns in Update-IR.
    task automatic ir_scan(input logic [3:0] din);
        logic [3:0] cap;
        cap = 4'b0001;
        for (int i = 0; i < 4; i++) exp_q.push_back(cap[i]);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, din[i]);
        tick(1'b1, 1'b0);
        chk("ir_drain", 32'(exp_q.size()), 32'd0);
        chk("ir_q_upd", 32'(ir_q), 32'(din));
    endtask

    initial begin
        logic [7:0] cap1;
        logic [7:0] din1;
        trst_n       = 1'b0;
        tms          = 1'b1;
        tdi          = 1'b0;
        user_capture = 16'h0000;
        #12;
        chk("rst_state", 32'(tap_state), 32'hF);
        chk("rst_ir", 32'(ir_q), 32'h1);
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_tdo_en", 32'(tdo_en), 32'd0);
        chk("rst_upd", 32'(user_update), 32'd0);
        chk("rst_stb", 32'(user_update_stb), 32'd0);
        @(negedge tck);
        #1;
        trst_n = 1'b1;

        // Reset and IDCODE default
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tlr_state", 32'(tap_state), 32'hF);
        tick(1'b0, 1'b0);
        chk("rti_state", 32'(tap_state), 32'hC);
        chk("rti_ir", 32'(ir_q), 32'h1);
        chk("rti_tdo_en", 32'(tdo_en), 32'd0);

        // IDCODE read
        dr_scan(32, 32'h0, 32'h4BA0_0477);
        tick(1'b0, 1'b0);

        // IR capture/load to BYPASS, then one-bit bypass delay
        ir_scan(4'hF);
        tick(1'b0, 1'b0);
        dr_scan(4, 32'b1101, 32'b1010);
        tick(1'b0, 1'b0);

        // USER0 write/read
        user_capture = 16'h00A5;
        ir_scan(4'h2);
        tick(1'b0, 1'b0);
        dr_scan(8, 32'h3C, 32'hA5);
        chk("u0_upd_lo", 32'(user_update[7:0]), 32'h3C);
        chk("u0_upd_hi", 32'(user_update[15:8]), 32'h00);
        chk("u0_stb", 32'(user_update_stb), 32'b01);
        tick(1'b0, 1'b0);
        chk("u0_stb_clr", 32'(user_update_stb), 32'b00);

        // USER1 with a pause in the middle of the shift
        cap1 = 8'h69;
        din1 = 8'hC3;
        user_capture = {cap1, 8'hA5};
        ir_scan(4'h3);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(cap1[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, din1[i]);
        chk("p_exit1", 32'(tap_state), 32'h1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        chk("p_pause", 32'(tap_state), 32'h3);
        tick(1'b1, 1'b0);
        chk("p_exit2", 32'(tap_state), 32'h0);
        tick(1'b0, 1'b0);
        for (int i = 4; i < 8; i++) tick(i == 7, din1[i]);
        tick(1'b1, 1'b0);
        chk("p_drain", 32'(exp_q.size()), 32'd0);
        chk("p_upd_hi", 32'(user_update[15:8]), 32'hC3);
        chk("p_upd_lo", 32'(user_update[7:0]), 32'h3C);
        chk("p_stb", 32'(user_update_stb), 32'b10);
        tick(1'b0, 1'b0);
        chk("p_stb_clr", 32'(user_update_stb), 32'b00);

        // Abort mid Shift-DR of USER1
        for (int i = 0; i < 8; i++) exp_q.push_back(cap1[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("ab_pre_state", 32'(tap_state), 32'h2);
        #2;
        trst_n = 1'b0;
        #1;
        chk("ab_state", 32'(tap_state), 32'hF);
        chk("ab_tdo_en", 32'(tdo_en), 32'd0);
        chk("ab_ir", 32'(ir_q), 32'h1);
        chk("ab_upd", 32'(user_update), 32'd0);
        chk("ab_stb", 32'(user_update_stb), 32'd0);
        exp_q.delete();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("ab_tms_ignored", 32'(tap_state), 32'hF);
        trst_n = 1'b1;
        tick(1'b0, 1'b0);
        chk("ab_rti", 32'(tap_state), 32'hC);

        // Pause-IR, then five tms=1 back to TLR
        exp_q.push_back(1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("pir_state", 32'(tap_state), 32'hB);
        chk("pir_drain", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("pir_tlr", 32'(tap_state), 32'hF);
        chk("pir_ir", 32'(ir_q), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised IEEE 1149.1 TAP core: 16-state TAP controller plus instruction register, decoder, BYPASS, IDCODE and NUM_USER_DR user data registers, with a negedge-retimed TDO mux. Sits directly behind the chip's JTAG pins and replaces the stand-alone TAP state machine. All DR/IR shifting is handled internally. User logic sees only parallel capture inputs, parallel update outputs and update strobes.

## Interface
- IR_WIDTH, 4: instruction register width, ≥2.
- IDCODE_VALUE, 32'h4BA0_0477: IDCODE register contents; bit 0 must be 1.
- NUM_USER_DR, 2: number of user data registers, 1..(2^IR_WIDTH − 3).
- USER_DR_WIDTH, 8: width of each user data register, ≥1.
- tck  in  1  JTAG test clock.
- trst_n  in  1  reset, asynchronous, active-low.
- tms  in  1  test mode select, sampled on posedge tck.
- tdi  in  1  test data in, sampled on posedge tck.
- tdo  out  1  test data out, changes on negedge tck.
- tdo_en  out  1  high while tdo is valid (Shift-DR/Shift-IR).
- tap_state  out  4  current TAP state encoding (debug).
- ir_q  out  IR_WIDTH  current instruction.
- user_capture  in  NUM_USER_DR*USER_DR_WIDTH  parallel capture data; slice k belongs to user DR k.
- user_update  out  NUM_USER_DR*USER_DR_WIDTH  parallel update registers.
- user_update_stb  out  NUM_USER_DR  one-tck-period strobe per user DR, high when slice k is updated.

## Operation
- TAP state encodings (hex): TLR F, RTI C, Select-DR 7, Capture-DR 6, Shift-DR 2, Exit1-DR 1, Pause-DR 3, Exit2-DR 0, Update-DR 5, Select-IR 4, Capture-IR E, Shift-IR A, Exit1-IR 9, Pause-IR B, Exit2-IR 8, Update-IR D.
- Transitions follow IEEE 1149.1. Illegal encodings go to TLR. Five posedges with tms=1 reach TLR from any state.
- Opcodes:
  - BYPASS = all ones.
  - IDCODE = 1.
  - USER k = k+2.
  - All other opcodes select BYPASS.
- IR capture value: {0…0,2'b01}.
- DR capture values:
  - BYPASS captures 0.
  - IDCODE captures IDCODE_VALUE.
  - USER k captures its user_capture slice.
- Shift order: LSB out on tdo, tdi enters MSB. Only the selected register shifts; the others hold.
- In TLR, ir_q is forced to IDCODE.

## Timing
- Reset values (trst_n low, asynchronous):
  - tap_state = 4'hF.
  - ir_q = IDCODE.
  - IR and DR shift registers = 0.
  - user_update = 0, user_update_stb = 0.
  - tdo = 0, tdo_en = 0.
- posedge tck:
  - State register updates.
  - Capture-xR loads the shift register.
  - Shift-xR shifts by one bit.
  - Exit/Pause states hold the shift register.
- negedge tck:
  - tdo <= LSB of the selected shift register.
  - tdo_en <= (state is Shift-DR or Shift-IR).
  - Outside shift states, tdo holds its last value.
- Update on negedge tck:
  - Update-IR loads ir_q from the IR shift register.
  - Update-DR with USER k loads user_update slice k and sets user_update_stb[k].
  - The strobe clears on the next negedge, giving a one-tck-period pulse.
- Decode sees the new ir_q from the first posedge after Update-IR.
- First tdo bit of a shift is valid from the negedge after the posedge that entered Shift-xR.
- Pause/Exit2 then re-entering Shift continues the same shift without recapture.
- trst_n asserted mid-shift aborts immediately: all reset values apply and user_update is cleared.
- tms is ignored while trst_n is low.
- USER_DR_WIDTH and IDCODE width are independent: the DR shift path width is per selected register, with no padding.

## Structure
- Package jtag_pkg holds:
  - tap_state_t enum with the encodings above.
  - Opcode constants as functions of IR_WIDTH (BYPASS, IDCODE, USER base 2).
  - IR capture constant.
- Sub-module jtag_tap_fsm holds the next-state logic, state register and state decodes (capture/shift/update for DR and IR).
- jtag_tap_core instantiates jtag_tap_fsm and contains the IR, decoder, data registers and TDO mux.

## Test plan
Parameters for all scenarios: defaults.
- **Reset and IDCODE default:** trst_n pulse, then tms=1×5, then 0 → tap_state 4'hC, ir_q = 4'h1, tdo_en = 0.
- **IDCODE read:** from RTI, tms 1,0,0, then 32 shifts with tdi=0 → tdo bits LSB-first equal 32'h4BA0_0477; tdo_en high only during the Shift-DR cycles.
- **IR capture/load:** shift IR with tdi 1,1,1,1 → tdo 1,0,0,0; after Update-IR, ir_q = 4'hF.
  - Then in Shift-DR, tdi 1,0,1,1 → tdo 0,1,0,1 (one-bit bypass delay).
- **USER0 write/read:** ir_q = 4'h2, user_capture[7:0] = 8'hA5, shift in 8'h3C → tdo yields A5 LSB-first.
  - After Update-DR: user_update[7:0] = 8'h3C; user_update_stb = 2'b01 for exactly one tck period; user_update[15:8] unchanged.
- **Pause mid-shift:** shift 4 bits, Exit1 → Pause ×3 → Exit2 → Shift 4 bits → total 8 bits consistent with an uninterrupted shift, no recapture.
- **Abort:** trst_n low during Shift-DR of USER1 → same cycle tap_state 4'hF, tdo_en 0, ir_q 4'h1, user_update all 0, no strobe.
  - Separately, tms=1×5 from Pause-IR → TLR.
